// File: rtl/dcm_prog_ctrl_pkg.sv
// Shared definitions for the DCM_CLKGEN dynamic reprogramming controller.
// State encoding, command prefixes, frame lengths and power-on M/D defaults.
package dcm_prog_ctrl_pkg;

    localparam int unsigned DATA_W   = 8;
    localparam int unsigned LOAD_LEN = 10;
    localparam int unsigned GAP_LEN  = 2;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_D,
        ST_GAP_D,
        ST_LOAD_M,
        ST_GAP_M,
        ST_GO,
        ST_WAIT_DONE
    } state_e;

    // Command prefixes, shifted out LSB first ahead of the 8-bit value
    localparam logic [1:0] CMD_LOAD_D = 2'b01;
    localparam logic [1:0] CMD_LOAD_M = 2'b11;

    // x20/6 power-on setting (registers hold value-1)
    localparam logic [DATA_W-1:0] RST_M = 8'd19;
    localparam logic [DATA_W-1:0] RST_D = 8'd5;

    function automatic logic load_bit(input logic [1:0]        cmd,
                                      input logic [DATA_W-1:0] val,
                                      input logic [CNT_W-1:0]  idx);
        logic [LOAD_LEN-1:0] word;
        word = {val, cmd};
        return word[idx];
    endfunction

endpackage

// File: rtl/dcm_prog_tick.sv
// progclk prescaler: progclk toggles every PCLK_DIV/2 clk cycles.
// rise_tick/fall_tick are high in the cycle whose closing edge drives progclk high/low.
module dcm_prog_tick #(
    parameter int unsigned PCLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic progclk,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int unsigned HALF  = PCLK_DIV / 2;
    localparam int unsigned PRE_W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [PRE_W-1:0] pre_q, pre_d;
    logic             progclk_q, progclk_d;
    logic             rise_tick_q, rise_tick_d;
    logic             fall_tick_q, fall_tick_d;
    logic             tick_next;

    // Ticks are registered one cycle ahead so they align with the progclk edge they announce
    always_comb begin
        pre_d       = (pre_q == PRE_W'(HALF - 1)) ? '0 : pre_q + PRE_W'(1);
        progclk_d   = (rise_tick_q || fall_tick_q) ? ~progclk_q : progclk_q;
        tick_next   = (pre_d == PRE_W'(HALF - 1));
        rise_tick_d = tick_next && !progclk_d;
        fall_tick_d = tick_next &&  progclk_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q       <= '0;
            progclk_q   <= 1'b0;
            rise_tick_q <= (HALF == 1);
            fall_tick_q <= 1'b0;
        end else begin
            pre_q       <= pre_d;
            progclk_q   <= progclk_d;
            rise_tick_q <= rise_tick_d;
            fall_tick_q <= fall_tick_d;
        end
    end

    assign progclk   = progclk_q;
    assign rise_tick = rise_tick_q;
    assign fall_tick = fall_tick_q;

endmodule

// File: rtl/dcm_prog_ctrl.sv
// Serialises new CLKFX M/D values into a DCM_CLKGEN programming port.
// Define DCM_PROG_TIMEOUT_EN to abort with err when PROGDONE never arrives.
module dcm_prog_ctrl
    import dcm_prog_ctrl_pkg::*;
#(
    parameter int unsigned PCLK_DIV      = 4,
    parameter int unsigned TIMEOUT_TICKS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] m_val,
    input  logic [DATA_W-1:0] d_val,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] cur_m,
    output logic [DATA_W-1:0] cur_d,
    output logic              dcm_progclk,
    output logic              dcm_progdata,
    output logic              dcm_progen,
    input  logic              dcm_progdone
);

    if (PCLK_DIV < 2 || (PCLK_DIV % 2) != 0 || TIMEOUT_TICKS == 0) begin : g_bad_cfg
        $error("dcm_prog_ctrl: PCLK_DIV must be even and >= 2, TIMEOUT_TICKS must be > 0");
    end

    logic rise_tick, fall_tick;

    dcm_prog_tick #(.PCLK_DIV(PCLK_DIV)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .progclk   (dcm_progclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] m_lat_q, m_lat_d, d_lat_q, d_lat_d;
    logic [DATA_W-1:0] cur_m_q, cur_m_d, cur_d_q, cur_d_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              progen_q, progen_d, progdata_q, progdata_d;

`ifdef DCM_PROG_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_TICKS + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`endif

    // cnt counts progclk periods already driven in the current frame state
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        m_lat_d    = m_lat_q;
        d_lat_d    = d_lat_q;
        cur_m_d    = cur_m_q;
        cur_d_d    = cur_d_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        progen_d   = progen_q;
        progdata_d = progdata_q;
`ifdef DCM_PROG_TIMEOUT_EN
        tmo_d      = tmo_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (m_val == '0) begin
                        err_d = 1'b1;
                    end else begin
                        state_d = ST_LOAD_D;
                        cnt_d   = '0;
                        m_lat_d = m_val;
                        d_lat_d = d_val;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_LOAD_D, ST_LOAD_M: begin
                if (fall_tick) begin
                    if (cnt_q == CNT_W'(LOAD_LEN)) begin
                        state_d    = (state_q == ST_LOAD_D) ? ST_GAP_D : ST_GAP_M;
                        progen_d   = 1'b0;
                        progdata_d = 1'b0;
                        cnt_d      = CNT_W'(1);
                    end else begin
                        progen_d   = 1'b1;
                        progdata_d = (state_q == ST_LOAD_D) ? load_bit(CMD_LOAD_D, d_lat_q, cnt_q)
                                                            : load_bit(CMD_LOAD_M, m_lat_q, cnt_q);
                        cnt_d      = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_GAP_D: begin
                if (fall_tick) begin
                    if (cnt_q == CNT_W'(GAP_LEN)) begin
                        state_d    = ST_LOAD_M;
                        progen_d   = 1'b1;
                        progdata_d = load_bit(CMD_LOAD_M, m_lat_q, CNT_W'(0));
                        cnt_d      = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_GAP_M: begin
                if (fall_tick) begin
                    if (cnt_q == CNT_W'(GAP_LEN)) begin
                        state_d    = ST_GO;
                        progen_d   = 1'b1;
                        progdata_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_GO: begin
                if (fall_tick) begin
                    state_d    = ST_WAIT_DONE;
                    progen_d   = 1'b0;
                    progdata_d = 1'b0;
`ifdef DCM_PROG_TIMEOUT_EN
                    tmo_d      = '0;
`endif
                end
            end
            ST_WAIT_DONE: begin
                if (rise_tick) begin
                    if (dcm_progdone) begin
                        cur_m_d = m_lat_q;
                        cur_d_d = d_lat_q;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end
`ifdef DCM_PROG_TIMEOUT_EN
                    else if (tmo_q == TMO_W'(TIMEOUT_TICKS - 1)) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
`endif
                end
            end
            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                progen_d   = 1'b0;
                progdata_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            m_lat_q    <= '0;
            d_lat_q    <= '0;
            cur_m_q    <= RST_M;
            cur_d_q    <= RST_D;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            progen_q   <= 1'b0;
            progdata_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            m_lat_q    <= m_lat_d;
            d_lat_q    <= d_lat_d;
            cur_m_q    <= cur_m_d;
            cur_d_q    <= cur_d_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            progen_q   <= progen_d;
            progdata_q <= progdata_d;
        end
    end

`ifdef DCM_PROG_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign cur_m        = cur_m_q;
    assign cur_d        = cur_d_q;
    assign dcm_progen   = progen_q;
    assign dcm_progdata = progdata_q;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Randomised directed bench for dcm_prog_ctrl with a frame-level reference model.
// Honours DCM_PROG_TIMEOUT_EN the same way as the design.
module tb_dcm_prog_ctrl;

    localparam int TMO = 1024;

    logic       clk = 1'b0;
    logic       reset, start, dcm_progdone;
    logic [7:0] m_val, d_val;

    logic       busy, done, err, pclk, pdata, pen;
    logic [7:0] cur_m, cur_d;
    logic       busy2, done2, err2, pclk2, pdata2, pen2;
    logic [7:0] cur_m2, cur_d2;
    logic       busy8, done8, err8, pclk8, pdata8, pen8;
    logic [7:0] cur_m8, cur_d8;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_m, exp_d;
    logic [1:0] obs[$];

    always #5 clk = ~clk;

    dcm_prog_ctrl #(.PCLK_DIV(4), .TIMEOUT_TICKS(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .m_val(m_val), .d_val(d_val),
        .busy(busy), .done(done), .err(err), .cur_m(cur_m), .cur_d(cur_d),
        .dcm_progclk(pclk), .dcm_progdata(pdata), .dcm_progen(pen),
        .dcm_progdone(dcm_progdone));

    dcm_prog_ctrl #(.PCLK_DIV(2), .TIMEOUT_TICKS(TMO)) dut2 (
        .clk(clk), .reset(reset), .start(start), .m_val(m_val), .d_val(d_val),
        .busy(busy2), .done(done2), .err(err2), .cur_m(cur_m2), .cur_d(cur_d2),
        .dcm_progclk(pclk2), .dcm_progdata(pdata2), .dcm_progen(pen2),
        .dcm_progdone(1'b1));

    dcm_prog_ctrl #(.PCLK_DIV(8), .TIMEOUT_TICKS(TMO)) dut8 (
        .clk(clk), .reset(reset), .start(start), .m_val(m_val), .d_val(d_val),
        .busy(busy8), .done(done8), .err(err8), .cur_m(cur_m8), .cur_d(cur_d8),
        .dcm_progclk(pclk8), .dcm_progdata(pdata8), .dcm_progen(pen8),
        .dcm_progdone(1'b1));

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    // Expected {progen,progdata} seen at each progclk rise from the first enabled period through GO
    function automatic logic [63:0] model_seq(input logic [7:0] m, input logic [7:0] d);
        logic [63:0] s;
        int          n;
        s = '0;
        n = 0;
        s[2*n +: 2] = 2'b11; n++;
        s[2*n +: 2] = 2'b10; n++;
        for (int i = 0; i < 8; i++) begin s[2*n +: 2] = {1'b1, d[i]}; n++; end
        n += 2;
        s[2*n +: 2] = 2'b11; n++;
        s[2*n +: 2] = 2'b11; n++;
        for (int i = 0; i < 8; i++) begin s[2*n +: 2] = {1'b1, m[i]}; n++; end
        n += 2;
        s[2*n +: 2] = 2'b10;
        return s;
    endfunction

    function automatic int first_en();
        for (int i = 0; i < obs.size(); i++)
            if (obs[i][1]) return i;
        return -1;
    endfunction

    // Monitor: sample just after each rising clk edge
    int   cyc = 0;
    logic prev_pclk[3] = '{0, 0, 0};
    logic prev_en[3]   = '{0, 0, 0};
    logic prev_dat[3]  = '{0, 0, 0};
    logic rst_since[3] = '{1, 1, 1};
    bit   have_rise[3] = '{0, 0, 0};
    int   last_rise[3] = '{0, 0, 0};
    localparam int DIVS[3] = '{4, 2, 8};

    always begin
        logic cp[3], ce[3], cd[3];
        @(posedge clk);
        #1;
        cyc++;
        cp = '{pclk, pclk2, pclk8};
        ce = '{pen,  pen2,  pen8};
        cd = '{pdata, pdata2, pdata8};
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                rst_since[i] = 1'b1;
            end else begin
                if (cp[i] && !prev_pclk[i]) begin
                    if (have_rise[i] && !rst_since[i])
                        chk($sformatf("progclk_period_div%0d", DIVS[i]), 64'(cyc - last_rise[i]), 64'(DIVS[i]));
                    last_rise[i] = cyc;
                    have_rise[i] = 1'b1;
                    rst_since[i] = 1'b0;
                    if (i == 0) obs.push_back({ce[i], cd[i]});
                end
                if (ce[i] != prev_en[i] || cd[i] != prev_dat[i])
                    chk($sformatf("bus_change_on_fall_div%0d", DIVS[i]), 64'({prev_pclk[i], cp[i]}), 64'(2'b10));
            end
            prev_pclk[i] = cp[i];
            prev_en[i]   = ce[i];
            prev_dat[i]  = cd[i];
        end
        if (!reset && (done || err))
            chk("done_err_exclusive", 64'(done & err), 64'(0));
    end

    task automatic wait_obs(input int n, input string tag);
        int b = 0;
        while (obs.size() < n && b < 2000) begin @(negedge clk); b++; end
        chk(tag, 64'(obs.size() >= n), 64'(1));
    endtask

    task automatic wait_en(output int k);
        int b = 0;
        while (first_en() < 0 && b < 200) begin @(negedge clk); b++; end
        chk("first_progen_seen", 64'(first_en() >= 0), 64'(1));
        k = (first_en() < 0) ? 0 : first_en();
    endtask

    task automatic issue(input logic [7:0] m, input logic [7:0] d);
        @(negedge clk);
        m_val = m; d_val = d; start = 1'b1;
        obs.delete();
        @(negedge clk);
        start = 1'b0;
        m_val = 8'($urandom);
        d_val = 8'($urandom);
    endtask

    task automatic run_txn(input logic [7:0] m, input logic [7:0] d, input int dly, input bit second);
        int          k, b;
        logic [63:0] ob;
        issue(m, d);
        chk("busy_on_accept", 64'(busy), 64'(1));
        wait_en(k);
        if (second) begin
            wait_obs(k + 14, "reach_load_m");
            m_val = 8'd40; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("busy_after_ignored_start", 64'(busy), 64'(1));
        end
        wait_obs(k + 25 + dly, "reach_wait_done");
        dcm_progdone = 1'b1;
        b = 0;
        while (done !== 1'b1 && b < 64) begin @(negedge clk); b++; end
        chk("done_pulse", 64'(done), 64'(1));
        chk("busy_drops_with_done", 64'(busy), 64'(0));
        chk("no_err_on_done", 64'(err), 64'(0));
        chk("cur_after_done", 64'({cur_m, cur_d}), 64'({m, d}));
        exp_m = m; exp_d = d;
        dcm_progdone = 1'b0;
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'(0));
        ob = '0;
        for (int i = 0; i < 25; i++) ob[2*i +: 2] = obs[k + i];
        chk("frame_bits", ob, model_seq(m, d));
        chk("bus_idle_in_wait", 64'(obs[k + 25]), 64'(0));
    endtask

    initial begin
        int   k, b;
        logic seen;
        logic [7:0] m, d;
        reset = 1'b1; start = 1'b0; m_val = '0; d_val = '0; dcm_progdone = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({busy, done, err, pclk, pdata, pen}), 64'(0));
        chk("reset_cur", 64'({cur_m, cur_d}), 64'({8'd19, 8'd5}));
        exp_m = 8'd19; exp_d = 8'd5;
        reset = 1'b0;

        run_txn(8'd23, 8'd5, 4, 1'b0);
        for (int t = 0; t < 4; t++)
            run_txn(8'($urandom_range(1, 255)), 8'($urandom), int'($urandom_range(0, 5)), 1'b0);

        // Reject m_val == 0
        for (int t = 0; t < 2; t++) begin
            issue(8'd0, 8'($urandom));
            chk("reject_err", 64'(err), 64'(1));
            chk("reject_busy", 64'(busy), 64'(0));
            seen = 1'b0;
            @(negedge clk);
            chk("reject_err_one_cycle", 64'(err), 64'(0));
            repeat (40) begin @(negedge clk); if (pen) seen = 1'b1; end
            chk("reject_no_progen", 64'(seen), 64'(0));
            chk("reject_cur_kept", 64'({cur_m, cur_d}), 64'({exp_m, exp_d}));
        end

        run_txn(8'($urandom_range(1, 255)), 8'($urandom), 2, 1'b1);

        // Reset during LOAD_M
        m = 8'($urandom_range(1, 255)); d = 8'($urandom);
        issue(m, d);
        wait_en(k);
        wait_obs(k + 14, "reach_load_m_rst");
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs", 64'({busy, done, err, pclk, pdata, pen}), 64'(0));
        chk("mid_reset_cur", 64'({cur_m, cur_d}), 64'({8'd19, 8'd5}));
        exp_m = 8'd19; exp_d = 8'd5;
        reset = 1'b0;
        obs.delete();
        repeat (120) @(negedge clk);
        chk("no_go_after_reset", 64'(first_en() >= 0), 64'(0));
        chk("idle_after_reset", 64'(busy), 64'(0));

        // PROGDONE never arrives
        m = 8'($urandom_range(1, 255)); d = 8'($urandom);
        issue(m, d);
        wait_en(k);
        wait_obs(k + 25, "reach_wait_done_tmo");
`ifdef DCM_PROG_TIMEOUT_EN
        b = 0;
        while (err !== 1'b1 && b < TMO * 4 + 200) begin @(negedge clk); b++; end
        chk("timeout_err", 64'(err), 64'(1));
        chk("timeout_busy", 64'(busy), 64'(0));
        chk("timeout_no_done", 64'(done), 64'(0));
        chk("timeout_cur_kept", 64'({cur_m, cur_d}), 64'({exp_m, exp_d}));
        chk("timeout_periods", 64'(obs.size() - (k + 25)), 64'(TMO));
`else
        seen = 1'b0;
        repeat (TMO * 4 + 400) begin @(negedge clk); if (err || done) seen = 1'b1; end
        chk("wait_forever_busy", 64'(busy), 64'(1));
        chk("wait_forever_no_pulse", 64'(seen), 64'(0));
        chk("wait_forever_cur_kept", 64'({cur_m, cur_d}), 64'({exp_m, exp_d}));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
`endif
        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
